// File: rtl/dmem_responder.sv
// Load/store responder: one request at a time against an internal word SRAM,
// with programmable wait states and sign/zero-extended load responses.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  dbg_state_o
);
    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends combinationally on ready, and a response stays
    // stable from rsp_valid rising until the edge where rsp_ready is seen.

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
    localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0]  WAIT_INIT = 4'(ZERO_WAIT ? 0 : WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] wdata_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic        accept;
    logic        exec_now;
    logic [31:0] ex_addr;
    logic        ex_write;
    logic [1:0]  ex_size;
    logic        ex_unsigned;
    logic [31:0] ex_wdata;
    logic [31:0] offset;
    logic        in_range;
    logic        misaligned;
    logic        ex_err;
    logic [AW-1:0] ex_idx;
    logic [31:0] rd_word;
    logic [31:0] lane;
    logic [31:0] load_data;
    logic [31:0] ex_rdata;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        mem_we;

    assign accept   = req_valid && req_ready_q;
    assign exec_now = (state_q == IDLE && accept && ZERO_WAIT) ||
                      (state_q == WAIT && cnt_q == 4'd0);

    // With zero wait states the request executes on its own accept edge,
    // so the live inputs are used instead of the latched copy.
    always_comb begin
        ex_addr     = addr_q;
        ex_write    = write_q;
        ex_size     = size_q;
        ex_unsigned = unsigned_q;
        ex_wdata    = wdata_q;
        if (state_q == IDLE) begin
            ex_addr     = req_addr;
            ex_write    = req_write;
            ex_size     = req_size;
            ex_unsigned = req_unsigned;
            ex_wdata    = req_wdata;
        end
    end

    always_comb begin
        offset   = ex_addr - BASE_ADDR;
        in_range = (ex_addr >= BASE_ADDR) && (offset < SPAN);
        ex_idx   = offset[AW+1:2];
        case (ex_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = ex_addr[0];
            2'b10:   misaligned = |ex_addr[1:0];
            default: misaligned = 1'b1;
        endcase
        ex_err = misaligned || !in_range;
    end

    always_comb begin
        rd_word = mem_q[ex_idx];
        lane    = rd_word >> {ex_addr[1:0], 3'b000};
        case (ex_size)
            2'b00:   load_data = ex_unsigned ? {24'd0, lane[7:0]}
                                             : {{24{lane[7]}}, lane[7:0]};
            2'b01:   load_data = ex_unsigned ? {16'd0, lane[15:0]}
                                             : {{16{lane[15]}}, lane[15:0]};
            default: load_data = lane;
        endcase
        ex_rdata = (ex_err || ex_write) ? 32'd0 : load_data;
    end

    always_comb begin
        case (ex_size)
            2'b00: begin
                wr_be   = 4'b0001 << ex_addr[1:0];
                wr_data = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = ex_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{ex_wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = ex_wdata;
            end
        endcase
    end

    // Reset on the commit edge drops a pending store.
    assign mem_we = exec_now && ex_write && !ex_err && !rst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem_q[ex_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'd0;
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            wdata_q     <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q      <= req_addr;
                        write_q     <= req_write;
                        size_q      <= req_size;
                        unsigned_q  <= req_unsigned;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (ZERO_WAIT) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rdata_q     <= ex_rdata;
                            err_q       <= ex_err;
                        end else begin
                            cnt_q   <= WAIT_INIT;
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rdata_q     <= ex_rdata;
                        err_q       <= ex_err;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: store/load lanes, extension, errors,
// backpressure, reset in WAIT/RESP, and latency for 0/1/3 wait states.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  dbg_state;

    logic        l_valid = 1'b0;
    logic        l_rsp_ready = 1'b0;
    logic        l0_req_ready, l0_rsp_valid, l0_rsp_err;
    logic        l3_req_ready, l3_rsp_valid, l3_rsp_err;
    logic [31:0] l0_rsp_rdata, l3_rsp_rdata;
    logic [1:0]  l0_state, l3_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0001_0000), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .dbg_state_o(dbg_state)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0001_0000), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst),
        .req_valid(l_valid), .req_ready(l0_req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(l0_rsp_valid), .rsp_ready(l_rsp_ready), .rsp_rdata(l0_rsp_rdata),
        .rsp_err(l0_rsp_err), .dbg_state_o(l0_state)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0001_0000), .WAIT_CYCLES(3)) dut_w3 (
        .clk(clk), .rst(rst),
        .req_valid(l_valid), .req_ready(l3_req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(l3_rsp_valid), .rsp_ready(l_rsp_ready), .rsp_rdata(l3_rsp_rdata),
        .rsp_err(l3_rsp_err), .dbg_state_o(l3_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1, idle again.
    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        set_req(wr, sz, uns, addr, wd);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic st(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd);
        logic [31:0] rd;
        logic er;
        int lat;
        do_req(tag, 1'b1, sz, 1'b0, addr, wd, rd, er, lat);
        check_eq({tag, "_err"}, {31'd0, er}, 32'd0);
        check_eq({tag, "_rdata"}, rd, 32'd0);
    endtask

    task automatic ld(input string tag, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic er;
        int lat;
        do_req(tag, 1'b0, sz, uns, addr, 32'd0, rd, er, lat);
        check_eq({tag, "_err"}, {31'd0, er}, 32'd0);
        check_eq({tag, "_rdata"}, rd, exp);
    endtask

    task automatic req_err(input string tag, input logic wr, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        logic er;
        int lat;
        do_req(tag, wr, sz, 1'b0, addr, wd, rd, er, lat);
        check_eq({tag, "_err"}, {31'd0, er}, 32'd1);
        check_eq({tag, "_rdata"}, rd, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic er;
        int lat, lat0, lat3;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rdata", rsp_rdata, 32'd0);
        check_eq("rst_err", {31'd0, rsp_err}, 32'd0);
        check_eq("rst_state", {30'd0, dbg_state}, 32'd0);

        // Word store then load, with latency
        do_req("sw0", 1'b1, 2'b10, 1'b0, 32'h0001_0010, 32'hDEAD_BEEF, rd, er, lat);
        check_eq("sw0_lat", lat, 32'd2);
        check_eq("sw0_rdata", rd, 32'd0);
        check_eq("sw0_err", {31'd0, er}, 32'd0);
        ld("lw0", 2'b10, 1'b0, 32'h0001_0010, 32'hDEAD_BEEF);

        // Byte lanes and extension
        st("sw1", 2'b10, 32'h0001_0010, 32'h1122_3344);
        st("sb0", 2'b00, 32'h0001_0013, 32'h1234_5680);
        ld("lw1", 2'b10, 1'b0, 32'h0001_0010, 32'h8022_3344);
        ld("lb3", 2'b00, 1'b0, 32'h0001_0013, 32'hFFFF_FF80);
        ld("lbu3", 2'b00, 1'b1, 32'h0001_0013, 32'h0000_0080);
        ld("lh2", 2'b01, 1'b0, 32'h0001_0012, 32'hFFFF_8022);
        ld("lhu2", 2'b01, 1'b1, 32'h0001_0012, 32'h0000_8022);
        ld("lh0", 2'b01, 1'b0, 32'h0001_0010, 32'h0000_3344);
        ld("lb1", 2'b00, 1'b0, 32'h0001_0011, 32'h0000_0033);
        st("sh2", 2'b01, 32'h0001_0012, 32'hFFFF_ABCD);
        ld("lw2", 2'b10, 1'b0, 32'h0001_0010, 32'hABCD_3344);

        // Errors and range boundaries
        st("sw_base", 2'b10, 32'h0001_0000, 32'h5566_7788);
        req_err("lw_mis", 1'b0, 2'b10, 32'h0001_0002, 32'd0);
        req_err("sh_mis", 1'b1, 2'b01, 32'h0001_0001, 32'h0000_FFFF);
        req_err("rsv_size", 1'b0, 2'b11, 32'h0001_0000, 32'd0);
        req_err("lw_below", 1'b0, 2'b10, 32'h0000_FFFC, 32'd0);
        req_err("lw_above", 1'b0, 2'b10, 32'h0001_1000, 32'd0);
        req_err("sw_above", 1'b1, 2'b10, 32'h0001_1000, 32'hCAFE_F00D);
        ld("lw_base", 2'b10, 1'b0, 32'h0001_0000, 32'h5566_7788);
        st("sw_top", 2'b10, 32'h0001_0FFC, 32'h0BAD_CAFE);
        ld("lw_top", 2'b10, 1'b0, 32'h0001_0FFC, 32'h0BAD_CAFE);

        // Backpressure with a second request held on the port
        set_req(1'b0, 2'b10, 1'b0, 32'h0001_0010, 32'd0);
        req_valid = 1'b1;
        @(posedge clk); #1;
        set_req(1'b0, 2'b00, 1'b1, 32'h0001_0013, 32'd0);
        check_eq("bp_wait_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check_eq("bp_rdata", rsp_rdata, 32'hABCD_3344);
            check_eq("bp_err", {31'd0, rsp_err}, 32'd0);
            check_eq("bp_req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_eq("bp_release_ready", {31'd0, req_ready}, 32'd1);
        check_eq("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("bp_held_accepted", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        check_eq("bp_held_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("bp_held_rdata", rsp_rdata, 32'h0000_00AB);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset during WAIT drops the store
        st("sw_a", 2'b10, 32'h0001_0020, 32'hAAAA_AAAA);
        ld("lw_a", 2'b10, 1'b0, 32'h0001_0020, 32'hAAAA_AAAA);
        set_req(1'b1, 2'b10, 1'b0, 32'h0001_0020, 32'h1234_5678);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("rw_in_wait", {30'd0, dbg_state}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rw_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rw_rdata", rsp_rdata, 32'd0);
        check_eq("rw_err", {31'd0, rsp_err}, 32'd0);
        ld("rw_lw", 2'b10, 1'b0, 32'h0001_0020, 32'hAAAA_AAAA);

        // Reset during RESP keeps the committed store
        set_req(1'b1, 2'b10, 1'b0, 32'h0001_0024, 32'h5A5A_5A5A);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("rr_in_resp", {31'd0, rsp_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        ld("rr_lw", 2'b10, 1'b0, 32'h0001_0024, 32'h5A5A_5A5A);

        // Latency with 0 and 3 wait states
        set_req(1'b1, 2'b10, 1'b0, 32'h0001_0040, 32'h0102_0304);
        l_valid = 1'b1;
        @(posedge clk); #1;
        l_valid = 1'b0;
        lat0 = 0;
        lat3 = 0;
        for (int c = 1; c <= 8; c++) begin
            if (l0_rsp_valid && lat0 == 0) lat0 = c;
            if (l3_rsp_valid && lat3 == 0) lat3 = c;
            @(posedge clk); #1;
        end
        check_eq("lat_w0", lat0, 32'd1);
        check_eq("lat_w3", lat3, 32'd4);
        l_rsp_ready = 1'b1;
        @(posedge clk); #1;
        l_rsp_ready = 1'b0;
        set_req(1'b0, 2'b10, 1'b0, 32'h0001_0040, 32'd0);
        l_valid = 1'b1;
        @(posedge clk); #1;
        l_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("w0_lw_rdata", l0_rsp_rdata, 32'h0102_0304);
        check_eq("w3_lw_rdata", l3_rsp_rdata, 32'h0102_0304);
        check_eq("w3_lw_err", {31'd0, l3_rsp_err}, 32'd0);
        l_rsp_ready = 1'b1;
        @(posedge clk); #1;
        l_rsp_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
